// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencing with heap coprocessor handshake
module hazard_ctrl #(
  parameter int HEAP_TIMEOUT = 1024,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_re_i,
  input  logic             id_rs2_re_i,
  input  logic [4:0]       exe_rdaddr_i,
  input  logic             exe_rdwe_i,
  input  logic             exe_is_load_i,
  input  logic             exe_redirect_i,
  input  logic             exe_heap_req_i,
  input  logic             heap_done_i,
  input  logic             mem_busy_i,
  input  logic             wb_trap_i,
  output logic [4:0]       stall_o,
  output logic [4:0]       flush_o,
  output logic             heap_start_o,
  output logic             heap_abort_o,
  output logic             heap_err_o,
  output logic [CNT_W-1:0] stall_cycles_o
);
  localparam int TW = $clog2(HEAP_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(HEAP_TIMEOUT - 1);
  typedef enum logic {IDLE, HEAP_WAIT} state_t;
  state_t r_state, w_st, w_next;
  logic [TW-1:0] r_tcnt;
  logic r_pend, r_err;
  logic [CNT_W-1:0] r_cnt;
  logic w_wait, w_done, w_rel, w_tout, w_entry, w_lu;
  // state, timeout counter, pending done, sticky error and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tcnt <= '0;
      r_pend <= 1'b0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_tcnt <= (!w_wait || w_next == IDLE) ? '0 : (r_tcnt == TMAX) ? r_tcnt : r_tcnt + 1'b1;
      r_pend <= w_wait && w_next == HEAP_WAIT && (r_pend || heap_done_i);
      r_err <= r_err | w_tout;
      r_cnt <= r_cnt + CNT_W'(stall_o[0]);
    end
  end
  // next-state: reset forces the comb view to IDLE; done beats timeout, trap beats done
  always_comb begin
    w_st = rst ? IDLE : r_state;
    w_wait = w_st == HEAP_WAIT;
    w_done = heap_done_i | r_pend;
    w_rel = w_wait & w_done & !mem_busy_i & !wb_trap_i;
    w_tout = w_wait & !w_done & !wb_trap_i & (r_tcnt == TMAX);
    w_entry = !w_wait & !rst & exe_heap_req_i & !wb_trap_i & !mem_busy_i;
    w_next = w_entry ? HEAP_WAIT : (w_rel | w_tout | (w_wait & wb_trap_i)) ? IDLE : w_st;
  end
  // outputs: priority decode of hold/bubble enables plus coprocessor pulses
  always_comb begin
    w_lu = exe_is_load_i & exe_rdwe_i & (exe_rdaddr_i != 5'd0) &
           ((id_rs1_re_i & (id_rs1_addr_i == exe_rdaddr_i)) | (id_rs2_re_i & (id_rs2_addr_i == exe_rdaddr_i)));
    heap_start_o = w_entry;
    heap_abort_o = w_wait & (wb_trap_i | w_tout);
    {stall_o, flush_o} = wb_trap_i ? {5'b00000, 5'b01111} :
                         mem_busy_i ? {5'b01111, 5'b10000} :
                         ((w_wait & !w_rel & !w_tout) | w_entry) ? {5'b00111, 5'b01000} :
                         exe_redirect_i ? {5'b00000, 5'b00110} :
                         w_lu ? {5'b00011, 5'b00100} : 10'd0;
  end
  assign heap_err_o = r_err;
  assign stall_cycles_o = r_cnt;
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage core. It sits beside the forwarding unit and decides, every cycle, which pipeline registers hold and which load a bubble. It covers load-use hazards, EXE-stage redirects, WB-stage traps, memory back-pressure and the multi-cycle heap coprocessor handshake. It also keeps a stall-cycle performance counter.

## Interface
Parameters:
- HEAP_TIMEOUT, default 1024 — maximum cycles spent in HEAP_WAIT before the heap operation is aborted.
- CNT_W, default 32 — width of the stall counter.

Ports:
- clk  in  1  — core clock; the only clock.
- rst  in  1  — synchronous, active-high reset.
- id_rs1_addr_i  in  5  — rs1 of the instruction in ID.
- id_rs2_addr_i  in  5  — rs2 of the instruction in ID.
- id_rs1_re_i  in  1  — ID reads rs1.
- id_rs2_re_i  in  1  — ID reads rs2.
- exe_rdaddr_i  in  5  — rd of the instruction in EXE.
- exe_rdwe_i  in  1  — EXE instruction writes rd.
- exe_is_load_i  in  1  — EXE instruction is a load.
- exe_redirect_i  in  1  — EXE resolved a taken branch/jump.
- exe_heap_req_i  in  1  — EXE holds a heap-coprocessor instruction.
- heap_done_i  in  1  — coprocessor result valid (one-cycle pulse).
- mem_busy_i  in  1  — MEM stage waiting on the bus.
- wb_trap_i  in  1  — trap/exception committing in WB.
- stall_o  out  5  — hold enables. bit0 PC, bit1 IF/ID, bit2 ID/EXE, bit3 EXE/MEM, bit4 MEM/WB.
- flush_o  out  5  — bubble-insert enables, same bit mapping.
- heap_start_o  out  1  — one-cycle start pulse to the coprocessor.
- heap_abort_o  out  1  — one-cycle abort pulse to the coprocessor.
- heap_err_o  out  1  — sticky timeout flag.
- stall_cycles_o  out  CNT_W  — count of cycles with stall_o[0]=1.

## Operation
State machine:
- States are IDLE and HEAP_WAIT.
- Registered state: a timeout counter and the done_pending flag.

IDLE → HEAP_WAIT:
- Condition: exe_heap_req_i=1 and no trap and mem_busy_i=0.
- heap_start_o=1 in that same cycle (Mealy).

HEAP_WAIT → IDLE happens on any of the following:
- heap_done_i (or done_pending) with mem_busy_i=0: release cycle.
- Timeout counter reaching HEAP_TIMEOUT-1: heap_abort_o=1 and heap_err_o is set.
- wb_trap_i: heap_abort_o=1.

done_pending:
- Set when heap_done_i arrives while mem_busy_i=1.
- Cleared on the release cycle.

Output decode is combinational, with the first matching row winning:
1. wb_trap_i: stall=00000, flush=01111.
2. mem_busy_i: stall=01111, flush=10000.
3. HEAP_WAIT without release, or the IDLE→HEAP_WAIT entry cycle: stall=00111, flush=01000.
4. exe_redirect_i: stall=00000, flush=00110.
5. Load-use: stall=00011, flush=00100.
   - Condition: exe_is_load_i & exe_rdwe_i & exe_rdaddr_i≠0 & ((id_rs1_re_i & rs1==rd) | (id_rs2_re_i & rs2==rd)).
6. Otherwise: stall=00000, flush=00000.

Other rules:
- Release, abort and timeout cycles fall through to rows 4–6.
- exe_heap_req_i and exe_redirect_i come from the same EXE instruction, so they are mutually exclusive. If both are asserted, the heap request wins.
- The timeout counter increments in HEAP_WAIT and also counts during mem_busy_i. It clears on entry to IDLE.
- stall_cycles_o increments by 1 on every cycle with stall_o[0]=1. It wraps modulo 2^CNT_W.

## Timing
Reset:
- When rst=1 at a clock edge: state=IDLE, counters=0, done_pending=0, heap_err_o=0, stall_cycles_o=0.
- Combinational outputs during reset evaluate against state IDLE. No abort pulse is generated by reset, even mid-HEAP_WAIT.

Latency:
- stall_o and flush_o act in the same cycle as their inputs.
- heap_start_o is asserted the cycle exe_heap_req_i is first seen in IDLE.
- The release cycle is the first cycle after heap_done_i where mem_busy_i=0. If mem_busy_i=0 on the heap_done_i cycle itself, that cycle is the release.

Boundary cases:
- heap_done_i and timeout in the same cycle: done wins. No abort, no error.
- heap_done_i during wb_trap_i: the trap wins and heap_abort_o pulses.
- heap_start_o is never asserted while in HEAP_WAIT.
- heap_start_o is never re-asserted for the same request. On the release cycle, the EXE/MEM register loads and the heap instruction leaves EXE.
- heap_err_o clears only on rst.

## Test plan
- Load-use: EXE load with rd=5, ID with rs1=5, rs1_re=1. Expect stall=00011, flush=00100 for exactly 1 cycle. Repeat with rd=0: expect no stall.
- Redirect and load-use together: expect flush=00110, stall=00000, and stall_cycles_o unchanged.
- Heap op: exe_heap_req_i for 1 cycle, heap_done_i 7 cycles later.
  - Expect heap_start_o pulse.
  - Expect 7 cycles of stall=00111/flush=01000, then a release cycle with stall=00000.
  - Expect stall_cycles_o=+7.
- Heap done during mem_busy_i held 3 cycles: expect stall=01111/flush=10000 throughout, release on the first cycle mem_busy_i=0, and heap_start_o not re-pulsed.
- Timeout with HEAP_TIMEOUT=16 and no heap_done_i: expect heap_abort_o pulse in HEAP_WAIT cycle 16, heap_err_o=1 held afterwards, and state IDLE.
- Mid-wait events:
  - wb_trap_i during HEAP_WAIT: expect flush=01111 and a heap_abort_o pulse.
  - rst during HEAP_WAIT: expect all outputs and counters at their reset values and no abort pulse.
